// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multiport register file.
package regfile_pkg;

    localparam int unsigned RF_DATA_W   = 32;
    localparam int unsigned RF_DEPTH    = 32;
    localparam int unsigned RF_NUM_READ = 2;
    localparam int unsigned RF_ADDR_W   = $clog2(RF_DEPTH);

    // Address width for a register file of the given depth.
    function automatic int unsigned rf_addr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/regfile_multiport_if.sv
// Decode/writeback side of the register file: read ports, write port, reservations.
interface regfile_multiport_if
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter int unsigned NUM_READ = RF_NUM_READ
);

    logic [NUM_READ*ADDR_W-1:0] ReadAddress;
    logic [NUM_READ*DATA_W-1:0] ReadData;
    logic [NUM_READ-1:0]        ReadBusy;
    logic                       WriteEn;
    logic [ADDR_W-1:0]          WriteAddress;
    logic [DATA_W-1:0]          WriteData;
    logic                       ReserveEn;
    logic [ADDR_W-1:0]          ReserveAddress;

    modport master (
        output ReadAddress, WriteEn, WriteAddress, WriteData, ReserveEn, ReserveAddress,
        input  ReadData, ReadBusy
    );

    modport slave (
        input  ReadAddress, WriteEn, WriteAddress, WriteData, ReserveEn, ReserveAddress,
        output ReadData, ReadBusy
    );

endinterface

// File: rtl/regfile_read_port.sv
// One registered read port: masks the hardwired-zero register and flops data/busy.
module regfile_read_port #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_mask,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_busy,
    output logic [DATA_W-1:0] o_data,
    output logic              o_busy
);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_data <= '0;
            o_busy <= 1'b0;
        end else if (i_mask) begin
            o_data <= '0;
            o_busy <= 1'b0;
        end else begin
            o_data <= i_data;
            o_busy <= i_busy;
        end
    end

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised register file with write-first bypass and a pending-write scoreboard.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned DEPTH    = RF_DEPTH,
    parameter int unsigned ADDR_W   = rf_addr_w(DEPTH),
    parameter int unsigned NUM_READ = RF_NUM_READ,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                CLK,
    input  logic                RST,
    regfile_multiport_if.slave  bus
);

    logic [DATA_W-1:0]          r_regs [DEPTH];
    logic [DEPTH-1:0]           r_busy;
    logic                       w_wr_ok;
    logic                       w_rs_ok;
    logic [NUM_READ*DATA_W-1:0] w_rdata;
    logic [NUM_READ-1:0]        w_rbusy;

    // Register 0 swallows writes and reservations when hardwired to zero.
    assign w_wr_ok = bus.WriteEn   && !(ZERO_REG && (bus.WriteAddress   == '0));
    assign w_rs_ok = bus.ReserveEn && !(ZERO_REG && (bus.ReserveAddress == '0));

    // Reservation is applied after the write so a same-edge reserve leaves busy set.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            if (w_wr_ok) begin
                r_regs[bus.WriteAddress] <= bus.WriteData;
                r_busy[bus.WriteAddress] <= 1'b0;
            end
            if (w_rs_ok) begin
                r_busy[bus.ReserveAddress] <= 1'b1;
            end
        end
    end

    for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic              w_wr_hit;
        logic              w_rs_hit;
        logic [DATA_W-1:0] w_data;
        logic              w_busy;
        logic              w_mask;

        assign w_addr   = bus.ReadAddress[p*ADDR_W +: ADDR_W];
        assign w_wr_hit = w_wr_ok && (bus.WriteAddress   == w_addr);
        assign w_rs_hit = w_rs_ok && (bus.ReserveAddress == w_addr);
        // Post-update view of the addressed register for this edge.
        assign w_data   = w_wr_hit ? bus.WriteData : r_regs[w_addr];
        assign w_busy   = w_rs_hit | (~w_wr_hit & r_busy[w_addr]);
        assign w_mask   = ZERO_REG && (w_addr == '0);

        regfile_read_port #(
            .DATA_W (DATA_W)
        ) u_port (
            .i_clk  (CLK),
            .i_rst  (RST),
            .i_mask (w_mask),
            .i_data (w_data),
            .i_busy (w_busy),
            .o_data (w_rdata[p*DATA_W +: DATA_W]),
            .o_busy (w_rbusy[p])
        );
    end

    assign bus.ReadData = w_rdata;
    assign bus.ReadBusy = w_rbusy;

endmodule

// File: doc/regfile_multiport.md
# regfile_multiport

Parametrised general-purpose register file for the RISC-V core. It replaces the fixed 32×32, two-read/one-write file with configurable data width, depth and read-port count. It adds synchronous reset, a hardwired-zero register, write-to-read bypass and a per-register pending-write scoreboard. It sits between decode (read addresses, reservations) and writeback (write port).

## Interface
- DATA_W, 32, register width in bits
- DEPTH, 32, number of registers (power of two, ≥2)
- ADDR_W, $clog2(DEPTH), address width (derived)
- NUM_READ, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1 register 0 reads as zero and ignores writes/reservations

- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- ReadAddress  in  NUM_READ*ADDR_W  packed read addresses, port i at [i*ADDR_W +: ADDR_W]
- ReadData  out  NUM_READ*DATA_W  packed registered read data, port i at [i*DATA_W +: DATA_W]
- ReadBusy  out  NUM_READ  per-port: addressed register has a pending write
- WriteEn  in  1  write strobe
- WriteAddress  in  ADDR_W  write target
- WriteData  in  DATA_W  write value
- ReserveEn  in  1  mark ReserveAddress as pending (instruction issued, result outstanding)
- ReserveAddress  in  ADDR_W  register to reserve

## Operation
- Reset (RST=1 at an edge): all registers ← 0, all busy bits ← 0, ReadData ← 0, ReadBusy ← 0. No initial preload; the bench loads values through the write port.
- RST has priority over every other input at the same edge. A write or reservation in a reset cycle is discarded.
- Write: at an edge with WriteEn=1, reg[WriteAddress] ← WriteData and busy[WriteAddress] ← 0.
- Reserve: at an edge with ReserveEn=1, busy[ReserveAddress] ← 1.
- Reserve and write to the same address at the same edge: data is written, busy ends at 1. The reservation belongs to a newer producer.
- ZERO_REG=1: writes and reservations to address 0 are ignored. Reads of address 0 return 0 with ReadBusy=0.
- Read, per port i, each edge:
  - ReadData[i] ← the value reg[ReadAddress[i]] holds after this edge's write.
  - This gives write-first bypass: a read and a write to the same address at the same edge returns WriteData.
- ReadBusy, per port i, each edge: ReadBusy[i] ← busy[ReadAddress[i]] as it stands after this edge's write and reserve updates.
- All read ports are independent. Any number of ports may address the same register.
- Addresses are ADDR_W bits wide, so every encoding is in range. No wrap-around or error handling is needed.

## Timing
- Read latency: 1 cycle. An address presented before edge N gives data valid after edge N. This is the same pipelining as the existing file.
- Write latency: 0 cycles to bypassed reads. A write at edge N is visible in ReadData after edge N.
- Scoreboard latency:
  - A reservation at edge N sets ReadBusy after edge N.
  - A write at edge N clears it after edge N, unless reserved again at the same edge.
- Reset mid-operation: outputs are 0 after the reset edge. The first post-reset edge behaves as the first edge after power-up.
- No handshake stalls. The block accepts one write and one reservation every cycle.

## Structure
- Shared package regfile_pkg holds:
  - default constants RF_DATA_W=32, RF_DEPTH=32, RF_NUM_READ=2;
  - localparam helper for ADDR_W.
- Storage and busy vector stay in regfile_multiport: a reg array of DEPTH×DATA_W plus a DEPTH-bit busy vector.
- Sub-module regfile_read_port is instantiated NUM_READ times by generate. Each instance:
  - takes the post-update data and busy values for its address;
  - applies the zero-register mask;
  - registers ReadData/ReadBusy with synchronous reset.

## Test plan
- Reset then read all addresses on both ports → ReadData=0 and ReadBusy=0 on every port.
- Write reg2=7, reg3=6 on consecutive cycles, then read addr 2/3 → ReadData0=7, ReadData1=6 one cycle later.
- At one edge, write reg5=0xDEADBEEF and read addr 5 on port 0 → ReadData0=0xDEADBEEF after that same edge (bypass).
- Scoreboard sequence on reg7:
  - reserve reg7, read addr 7 → ReadBusy0=1;
  - write reg7=0x11 → ReadBusy0=0;
  - reserve and write reg7 at the same edge → data 0x11 stored, ReadBusy0=1.
- ZERO_REG=1: write reg0=0xFFFFFFFF and reserve reg0, then read addr 0 on all ports → ReadData=0, ReadBusy=0.
- Reset mid-operation: load reg9=0x55 and reserve reg4, assert RST for one edge, then read 9 and 4 → ReadData=0, ReadBusy=0. Repeat with NUM_READ=4, DATA_W=64, DEPTH=16.
